// File: rtl/cluster_pkg.sv
// Shared types and constants for the cluster frame packer: cluster slot and frame entry
// layouts, output word field positions and the word formatter.
package cluster_pkg;

  localparam int unsigned NCLUSTERS   = 8;
  localparam int unsigned ADR_W       = 11;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned NSTRIPS     = 1536;
  localparam int unsigned FIFO_FRAMES = 2;
  localparam int unsigned DROP_W      = 16;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned NV_W        = $clog2(NCLUSTERS + 1);
  localparam int unsigned IDX_W       = $clog2(NCLUSTERS);

  localparam int unsigned VALID_BIT   = 15;
  localparam int unsigned LAST_BIT    = 14;
  localparam int unsigned CNT_LSB     = 11;

  localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_t;

  typedef struct packed {
    cluster_t [NCLUSTERS-1:0] slots;
    logic [NV_W-1:0]          nvalid;
    logic                     ovf;
  } frame_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pack_state_e;

  // Word for slot idx of a frame; an empty frame yields a single invalid last-word marker.
  function automatic logic [WORD_W-1:0] format_word(input frame_entry_t e,
                                                    input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    if (e.nvalid == '0) begin
      w[LAST_BIT]             = 1'b1;
      w[ADR_W-1:0]            = INVALID_ADR;
    end else begin
      w[VALID_BIT]            = 1'b1;
      w[LAST_BIT]             = (NV_W'(idx) == NV_W'(e.nvalid - NV_W'(1)));
      w[CNT_LSB +: CNT_W]     = e.slots[idx].cnt;
      w[ADR_W-1:0]            = e.slots[idx].adr;
    end
    return w;
  endfunction

endpackage

// File: rtl/cluster_frame_packer_if.sv
// Frame capture input and word stream output of the packer; master is the packer side,
// slave is the cluster finder / link formatter environment.
interface cluster_frame_packer_if;
  import cluster_pkg::*;

  logic                       frame_valid;
  logic [NCLUSTERS*ADR_W-1:0] adr_in;
  logic [NCLUSTERS*CNT_W-1:0] cnt_in;
  logic [WORD_W-1:0]          word_data;
  logic                       word_valid;
  logic                       word_ready;
  logic                       word_overflow;
  logic [DROP_W-1:0]          drop_cnt;

  modport master (
    input  frame_valid, adr_in, cnt_in, word_ready,
    output word_data, word_valid, word_overflow, drop_cnt
  );

  modport slave (
    output frame_valid, adr_in, cnt_in, word_ready,
    input  word_data, word_valid, word_overflow, drop_cnt
  );

endinterface

// File: rtl/cluster_frame_fifo.sv
// Small frame buffer; a push while full is accepted when the head is popped in the same cycle.
module cluster_frame_fifo
  import cluster_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_FRAMES
) (
  input  logic         clock4x,
  input  logic         global_reset_n,
  input  logic         push,
  input  frame_entry_t push_data,
  input  logic         pop,
  output frame_entry_t head_data,
  output frame_entry_t next_data_c,
  output logic         empty,
  output logic         full,
  output logic         more_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  frame_entry_t     mem_q [DEPTH];
  frame_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign more_c      = (count_q >= CW'(2));
  assign head_data   = mem_q[rptr_q];
  assign next_data_c = mem_q[PTR_W'(rptr_q + PTR_W'(1))];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_en   = pop && !empty;
    wr_en   = push && (!full || rd_en);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (wr_en) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = PTR_W'(wptr_q + PTR_W'(1));
    end
    if (rd_en) rptr_d = PTR_W'(rptr_q + PTR_W'(1));
    case ({wr_en, rd_en})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/cluster_frame_packer.sv
// Captures one cluster frame per strobe, buffers it, and streams the leading valid clusters
// as 16-bit words over valid/ready; frames arriving to a full buffer are dropped and counted.
module cluster_frame_packer
  import cluster_pkg::*;
(
  input  logic                   clock4x,
  input  logic                   global_reset_n,
  cluster_frame_packer_if.master bus
);

  frame_entry_t      cap_entry;
  logic              leading;
  frame_entry_t      head_data, next_data;
  logic              fifo_empty, fifo_full, fifo_more;

  pack_state_e       state_q, state_d;
  frame_entry_t      cur_q, cur_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              word_overflow_q, word_overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              accept, last_word, pop;

  // Only the run of in-range slots starting at slot 0 counts as valid.
  always_comb begin
    cap_entry = '0;
    leading   = 1'b1;
    for (int unsigned k = 0; k < NCLUSTERS; k++) begin
      cap_entry.slots[k].adr = bus.adr_in[k*ADR_W +: ADR_W];
      cap_entry.slots[k].cnt = bus.cnt_in[k*CNT_W +: CNT_W];
      if (leading && (cap_entry.slots[k].adr < ADR_W'(NSTRIPS)))
        cap_entry.nvalid = NV_W'(cap_entry.nvalid + NV_W'(1));
      else
        leading = 1'b0;
    end
    cap_entry.ovf = (cap_entry.nvalid == NV_W'(NCLUSTERS));
  end

  cluster_frame_fifo #(.DEPTH(FIFO_FRAMES)) u_fifo (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .push           (bus.frame_valid),
    .push_data      (cap_entry),
    .pop            (pop),
    .head_data      (head_data),
    .next_data_c    (next_data),
    .empty          (fifo_empty),
    .full           (fifo_full),
    .more_c         (fifo_more)
  );

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      state_q         <= ST_IDLE;
      cur_q           <= '0;
      idx_q           <= '0;
      word_data_q     <= '0;
      word_valid_q    <= 1'b0;
      word_overflow_q <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      idx_q           <= idx_d;
      word_data_q     <= word_data_d;
      word_valid_q    <= word_valid_d;
      word_overflow_q <= word_overflow_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // Next state: the first SEND cycle prepares the registered word; later cycles stream it.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    idx_d     = idx_q;
    accept    = (state_q == ST_SEND) && word_valid_q && bus.word_ready;
    last_word = (cur_q.nvalid == '0) || (NV_W'(idx_q) == NV_W'(cur_q.nvalid - NV_W'(1)));
    pop       = accept && last_word;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cur_d   = head_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (last_word) begin
            if (fifo_more) begin
              cur_d = next_data;
              idx_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so an accepted word is replaced at once.
  always_comb begin
    word_valid_d    = (state_q == ST_SEND) && (state_d == ST_SEND);
    word_data_d     = '0;
    word_overflow_d = 1'b0;
    drop_cnt_d      = drop_cnt_q;
    if (word_valid_d) begin
      word_data_d     = format_word(cur_d, idx_d);
      word_overflow_d = cur_d.ovf;
    end
    if (bus.frame_valid && fifo_full && !pop && (drop_cnt_q != '1))
      drop_cnt_d = DROP_W'(drop_cnt_q + DROP_W'(1));
  end

  assign bus.word_data     = word_data_q;
  assign bus.word_valid    = word_valid_q;
  assign bus.word_overflow = word_overflow_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_cluster_frame_packer.sv
// Scoreboard bench for cluster_frame_packer: directed frames push expected words, a negedge
// monitor pops and compares every accepted word.
module tb_cluster_frame_packer;
  import cluster_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cluster_frame_packer_if bus ();

  cluster_frame_packer dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .bus            (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [NCLUSTERS-1:0][ADR_W-1:0] va;
  logic [NCLUSTERS-1:0][CNT_W-1:0] vc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input int a, input int c);
    va[k] = ADR_W'(a);
    vc[k] = CNT_W'(c);
  endtask

  task automatic fill_invalid();
    for (int k = 0; k < NCLUSTERS; k++) set_slot(k, 'h7FF, 0);
  endtask

  task automatic expect_word(input logic [15:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; the frame is sampled on the next edge.
  task automatic strobe();
    bus.frame_valid = 1'b1;
    bus.adr_in      = va;
    bus.cnt_in      = vc;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.word_valid) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
    end
  endtask

  // Scoreboard monitor: one comparison per handshake.
  always @(negedge clk) begin
    if (rst_n && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", bus.word_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", 32'(bus.word_data), 32'(mon_e.data));
        check("word_overflow", 32'(bus.word_overflow), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.frame_valid = 1'b0;
    bus.adr_in      = '0;
    bus.cnt_in      = '0;
    bus.word_ready  = 1'b1;
    fill_invalid();
    tick(); tick(); tick();
    check("rst_valid", 32'(bus.word_valid), 32'h0);
    check("rst_data", 32'(bus.word_data), 32'h0);
    check("rst_ovf", 32'(bus.word_overflow), 32'h0);
    check("rst_drop", 32'(bus.drop_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Three leading valid slots, then an invalid one; latency check.
    fill_invalid();
    set_slot(0, 5, 1); set_slot(1, 100, 2); set_slot(2, 1535, 7);
    set_slot(4, 0, 0);
    expect_word(16'h8805, 1'b0);
    expect_word(16'h9064, 1'b0);
    expect_word(16'hFDFF, 1'b0);
    strobe();
    check("lat_T", 32'(bus.word_valid), 32'h0);
    tick();
    check("lat_T1", 32'(bus.word_valid), 32'h0);
    tick();
    check("lat_T2", 32'(bus.word_valid), 32'h1);
    check("lat_T2_data", 32'(bus.word_data), 32'h8805);
    wait_drain("three");

    // Empty frames: all invalid, slot 0 at NSTRIPS, slot 0 invalid but slot 1 valid.
    fill_invalid();
    expect_word(16'h47FF, 1'b0);
    strobe();
    wait_drain("empty_all");
    fill_invalid();
    set_slot(0, 1536, 5);
    expect_word(16'h47FF, 1'b0);
    strobe();
    wait_drain("empty_1536");
    fill_invalid();
    set_slot(0, 2000, 1); set_slot(1, 10, 2);
    expect_word(16'h47FF, 1'b0);
    strobe();
    wait_drain("empty_gap");

    // All eight slots valid: overflow flagged on every word.
    for (int k = 0; k < NCLUSTERS; k++) begin
      set_slot(k, k, 3);
      expect_word((k == NCLUSTERS - 1) ? 16'hD807 : 16'(16'h9800 + k), 1'b1);
    end
    strobe();
    wait_drain("full8");

    // Stall: two frames buffered, third dropped, replay without bubble.
    bus.word_ready = 1'b0;
    fill_invalid();
    set_slot(0, 10, 1); set_slot(1, 11, 2);
    expect_word(16'h880A, 1'b0);
    expect_word(16'hD00B, 1'b0);
    strobe();
    for (int i = 0; i < 7; i++) tick();
    fill_invalid();
    set_slot(0, 20, 4);
    expect_word(16'hE014, 1'b0);
    strobe();
    for (int i = 0; i < 7; i++) tick();
    fill_invalid();
    set_slot(0, 30, 5);
    strobe();
    check("drop_one", 32'(bus.drop_cnt), 32'h1);
    check("stall_valid", 32'(bus.word_valid), 32'h1);
    check("stall_data0", 32'(bus.word_data), 32'h880A);
    for (int i = 0; i < 4; i++) tick();
    check("stall_data1", 32'(bus.word_data), 32'h880A);
    check("stall_ovf", 32'(bus.word_overflow), 32'h0);
    bus.word_ready = 1'b1;
    tick();
    check("replay_w1_valid", 32'(bus.word_valid), 32'h1);
    tick();
    check("replay_nobubble", 32'(bus.word_valid), 32'h1);
    check("replay_f2_data", 32'(bus.word_data), 32'hE014);
    tick();
    check("replay_end", 32'(bus.word_valid), 32'h0);
    wait_drain("stall");

    // Full buffer with last-word acceptance in the same cycle as a new strobe.
    bus.word_ready = 1'b0;
    fill_invalid();
    set_slot(0, 40, 1);
    expect_word(16'hC828, 1'b0);
    strobe();
    tick(); tick(); tick();
    fill_invalid();
    set_slot(0, 41, 2);
    expect_word(16'hD029, 1'b0);
    strobe();
    tick(); tick(); tick();
    fill_invalid();
    set_slot(0, 42, 3);
    expect_word(16'hD82A, 1'b0);
    bus.word_ready = 1'b1;
    strobe();
    check("popsame_drop", 32'(bus.drop_cnt), 32'h1);
    check("popsame_next", 32'(bus.word_data), 32'hD029);
    wait_drain("popsame");
    check("popsame_drop_end", 32'(bus.drop_cnt), 32'h1);

    // Reset after two of five words are accepted.
    for (int k = 0; k < 5; k++) set_slot(k, 50 + k, 2);
    for (int k = 5; k < NCLUSTERS; k++) set_slot(k, 'h7FF, 0);
    expect_word(16'h9032, 1'b0);
    expect_word(16'h9033, 1'b0);
    strobe();
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(bus.word_valid), 32'h0);
    check("midrst_data", 32'(bus.word_data), 32'h0);
    check("midrst_drop", 32'(bus.drop_cnt), 32'h0);
    check("midrst_queue", 32'(exp_q.size()), 32'h0);
    tick(); tick(); tick();
    check("midrst_empty", 32'(bus.word_valid), 32'h0);
    fill_invalid();
    set_slot(0, 60, 6); set_slot(1, 61, 1);
    expect_word(16'hB03C, 1'b0);
    expect_word(16'hC83D, 1'b0);
    strobe();
    wait_drain("after_rst");

    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
